// File: rtl/ltc2320_pkg.sv
// Shared constants and FSM encoding for the LTC2320 slave emulator and its driver.
// The timing constants describe the CNV pulse width and sampling wait the driver uses.
package ltc2320_pkg;

  localparam int LTC2320_LANES      = 8;
  localparam int DEFAULT_FRAME_BITS = 16;
  localparam int CNV_PULSE_CLK      = 6;
  localparam int SAMPLE_WAIT_CLK    = 90;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin, followed by one history flop
// that yields single-cycle rise and fall pulses.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/ltc2320_emu.sv
// Slave-side emulator of an 8-lane LTC2320: latches fabric samples on CNV_n rise,
// waits the conversion time, then shifts each lane out MSB first on SCK falls.
module ltc2320_emu
  import ltc2320_pkg::*;
#(
  parameter int CONV_CYCLES = 60,
  parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                CNV_n,
  input  logic                                SCK,
  output logic [LTC2320_LANES-1:0]            SDO,
  output logic                                CLKOUT,
  input  logic [LTC2320_LANES*FRAME_BITS-1:0] data_in,
  output logic                                sample_req,
  output logic                                busy,
  output logic                                err_sck,
  input  logic                                err_clr
);

  localparam logic [7:0] CONV_LAST  = 8'(CONV_CYCLES - 1);
  localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);
  localparam logic [4:0] FRAME_SAT  = 5'(FRAME_BITS);

  state_e     state_q, state_d;
  logic [7:0] conv_cnt_q, conv_cnt_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic       frame_done_q, frame_done_d;
  logic       err_q, err_d;

  logic cnv_level, cnv_rise, cnv_fall;
  logic sck_level, sck_rise, sck_fall;
  logic load_shift, do_shift, last_fall, err_event;
  logic [LTC2320_LANES-1:0] lane_msb;
  logic unused_cnv;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_cnv_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (CNV_n),
    .level (cnv_level),
    .rise  (cnv_rise),
    .fall  (cnv_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (SCK),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  assign unused_cnv = cnv_level ^ cnv_fall;

  // A CNV rise always wins over a same-cycle SCK fall.
  assign load_shift = (state_q == ST_CONV) && (conv_cnt_q == CONV_LAST) && !cnv_rise;
  assign do_shift   = (state_q == ST_SHIFT) && sck_fall && !cnv_rise;
  assign last_fall  = do_shift && (bit_cnt_q == FRAME_LAST);
  assign err_event  = !cnv_rise &&
                      (((state_q == ST_CONV) && (sck_rise || sck_fall)) ||
                       ((state_q == ST_IDLE) && frame_done_q && sck_fall));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cnv_rise) begin
      state_d = ST_CONV;
    end else begin
      case (state_q)
        ST_CONV:  if (load_shift) state_d = ST_SHIFT;
        ST_SHIFT: if (last_fall)  state_d = ST_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    SDO        = (state_q == ST_SHIFT) ? lane_msb : '0;
    busy       = (state_q != ST_IDLE);
    sample_req = cnv_rise;
    err_sck    = err_q;
    CLKOUT     = sck_level;
  end

  always_comb begin
    conv_cnt_d   = conv_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = frame_done_q;
    err_d        = err_q;
    if (cnv_rise) begin
      conv_cnt_d   = '0;
      bit_cnt_d    = '0;
      frame_done_d = 1'b0;
    end else begin
      if ((state_q == ST_CONV) && (conv_cnt_q != 8'hFF)) conv_cnt_d = conv_cnt_q + 8'd1;
      if (load_shift) bit_cnt_d = '0;
      else if (do_shift && (bit_cnt_q != FRAME_SAT)) bit_cnt_d = bit_cnt_q + 5'd1;
      if (last_fall) frame_done_d = 1'b1;
    end
    // Set beats clear when both land in the same cycle.
    if (err_event)    err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      conv_cnt_q   <= conv_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LTC2320_LANES; gi++) begin : g_lane
      logic [FRAME_BITS-1:0] shadow_q, shadow_d;
      logic [FRAME_BITS-1:0] shift_q, shift_d;

      always_comb begin
        shadow_d = shadow_q;
        shift_d  = shift_q;
        if (cnv_rise) begin
          shadow_d = data_in[gi*FRAME_BITS +: FRAME_BITS];
          shift_d  = '0;
        end else if (load_shift) begin
          shift_d = shadow_q;
        end else if (do_shift) begin
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_q <= '0;
          shift_q  <= '0;
        end else begin
          shadow_q <= shadow_d;
          shift_q  <= shift_d;
        end
      end

      assign lane_msb[gi] = shift_q[FRAME_BITS-1];
    end
  endgenerate

endmodule
